// File: rtl/filter_scheduler.sv
// Round-robin scheduler that time-shares one filter datapath among four channels,
// with per-job timeout, sticky overrun tracking and a registered result capture.
module filter_scheduler #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req,
  input  logic [32*NCH-1:0]   ch_data,
  input  logic [NCH-1:0]      ch_sign,
  input  logic                clr_ovr,
  output logic                flt_enable,
  output logic [31:0]         flt_datain,
  output logic                flt_sign,
  input  logic                flt_over,
  input  logic [31:0]         flt_result,
  output logic [31:0]         result,
  output logic [1:0]          result_ch,
  output logic                result_valid,
  output logic                timeout_err,
  output logic [NCH-1:0]      overrun,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  localparam logic [15:0] LastCount = 16'(TIMEOUT - 1);

  state_e         state_q;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     last_grant_q;
  logic [1:0]     idx;
  logic [15:0]    cnt_q;
  logic           flt_enable_q, flt_sign_q;
  logic [31:0]    flt_datain_q, result_q;
  logic [1:0]     result_ch_q;
  logic           result_valid_q, timeout_err_q, busy_q;
  logic           job_done;
  logic [NCH-1:0] done_mask;

  // Walk downward so the nearest pending channel after last_grant overwrites the rest.
  always_comb begin
    grant_d = last_grant_q + 2'd1;
    idx     = last_grant_q;
    for (int i = NCH; i >= 1; i--) begin
      idx = last_grant_q + 2'(i);
      if (pending_q[idx]) grant_d = idx;
    end
  end

  assign job_done  = (state_q == RUN) && (flt_over || (cnt_q == LastCount));
  assign done_mask = job_done ? (NCH'(1) << grant_q) : '0;

  // A new request always survives a same-cycle clear, for both pending and overrun.
  assign pending_d = (pending_q & ~done_mask) | req;
  assign overrun_d = (clr_ovr ? '0 : overrun_q) | (req & pending_q & ~done_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      overrun_q      <= '0;
      grant_q        <= 2'd0;
      last_grant_q   <= 2'd3;
      cnt_q          <= 16'd0;
      flt_enable_q   <= 1'b0;
      flt_sign_q     <= 1'b0;
      flt_datain_q   <= 32'd0;
      result_q       <= 32'd0;
      result_ch_q    <= 2'd0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          flt_datain_q <= ch_data[{grant_q, 5'd0} +: 32];
          flt_sign_q   <= ch_sign[grant_q];
          flt_enable_q <= 1'b1;
          cnt_q        <= 16'd0;
          state_q      <= RUN;
        end
        RUN: begin
          if (flt_over) begin
            result_q       <= flt_result;
            result_ch_q    <= grant_q;
            result_valid_q <= 1'b1;
            flt_enable_q   <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else if (cnt_q == LastCount) begin
            timeout_err_q <= 1'b1;
            flt_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign flt_enable   = flt_enable_q;
  assign flt_datain   = flt_datain_q;
  assign flt_sign     = flt_sign_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler: arbitration order, latency, timeout,
// overrun flags, reset mid-job and stray completion pulses.
module tb_filter_scheduler;

  logic         clk = 1'b0;
  logic         rstN;
  logic [3:0]   req;
  logic [127:0] chData;
  logic [3:0]   chSign;
  logic         clrOvr;
  logic         fltEnable;
  logic [31:0]  fltDatain;
  logic         fltSign;
  logic         fltOver;
  logic [31:0]  fltResult;
  logic [31:0]  result;
  logic [1:0]   resultCh;
  logic         resultValid;
  logic         timeoutErr;
  logic [3:0]   overrun;
  logic         busy;

  int vecCount = 0;
  int errCount = 0;

  filter_scheduler #(.NCH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rstN), .req(req), .ch_data(chData), .ch_sign(chSign),
    .clr_ovr(clrOvr), .flt_enable(fltEnable), .flt_datain(fltDatain),
    .flt_sign(fltSign), .flt_over(fltOver), .flt_result(fltResult),
    .result(result), .result_ch(resultCh), .result_valid(resultValid),
    .timeout_err(timeoutErr), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic ovr, input logic [31:0] res, input logic clr);
    req       = r;
    fltOver   = ovr;
    fltResult = res;
    clrOvr    = clr;
  endtask

  task automatic doReset;
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
  endtask

  // Entered in IDLE with the channel about to be granted; leaves right after the completion edge.
  task automatic serviceJob(input logic [1:0] ch, input logic [31:0] data, input logic sign,
                            input int nRun, input logic [31:0] res, input bit scramble);
    checkOutput("idleEnable", 32'(fltEnable), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    tick;
    checkOutput("loadBusy", 32'(busy), 32'd1);
    checkOutput("loadEnable", 32'(fltEnable), 32'd0);
    checkOutput("validPulse", 32'(resultValid), 32'd0);
    tick;
    checkOutput("runEnable", 32'(fltEnable), 32'd1);
    checkOutput("runData", fltDatain, data);
    checkOutput("runSign", 32'(fltSign), 32'(sign));
    if (scramble) begin
      chData = ~chData;
      chSign = ~chSign;
    end
    for (int i = 1; i < nRun; i++) begin
      tick;
      checkOutput("runHold", 32'(fltEnable), 32'd1);
    end
    applyStimulus(4'b0000, 1'b1, res, 1'b0);
    tick;
    applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
    checkOutput("resValid", 32'(resultValid), 32'd1);
    checkOutput("result", result, res);
    checkOutput("resultCh", 32'(resultCh), 32'(ch));
    checkOutput("doneEnable", 32'(fltEnable), 32'd0);
    checkOutput("heldData", fltDatain, data);
    checkOutput("heldSign", 32'(fltSign), 32'(sign));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int onCount;
    rstN   = 1'b0;
    chData = '0;
    chSign = '0;
    applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
    repeat (2) tick;
    checkOutput("rstEnable", 32'(fltEnable), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstResultCh", 32'(resultCh), 32'd0);
    checkOutput("rstValid", 32'(resultValid), 32'd0);
    checkOutput("rstTimeout", 32'(timeoutErr), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    checkOutput("rstDatain", fltDatain, 32'd0);
    checkOutput("rstSign", 32'(fltSign), 32'd0);
    rstN = 1'b1;

    // Stray completion pulse while idle
    applyStimulus(4'b0000, 1'b1, 32'hDEAD, 1'b0);
    tick;
    applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
    checkOutput("strayValid", 32'(resultValid), 32'd0);
    checkOutput("strayResult", result, 32'd0);
    checkOutput("strayBusy", 32'(busy), 32'd0);

    // All four channels at once: served 0,1,2,3
    chData = {32'd400, 32'd300, 32'd200, 32'd100};
    chSign = 4'b1010;
    applyStimulus(4'b1111, 1'b0, 32'd0, 1'b0);
    tick;
    req = 4'b0000;
    serviceJob(2'd0, 32'd100, 1'b0, 2, 32'h1000, 1'b0);
    serviceJob(2'd1, 32'd200, 1'b1, 2, 32'h1001, 1'b0);
    serviceJob(2'd2, 32'd300, 1'b0, 2, 32'h1002, 1'b0);
    serviceJob(2'd3, 32'd400, 1'b1, 2, 32'h1003, 1'b0);
    tick;
    checkOutput("drainBusy", 32'(busy), 32'd0);
    checkOutput("drainValid", 32'(resultValid), 32'd0);

    // Single job, three RUN cycles, inputs disturbed after LOAD
    chData[31:0] = 32'd50000;
    chSign       = 4'b0000;
    req = 4'b0001;
    tick;
    req = 4'b0000;
    serviceJob(2'd0, 32'd50000, 1'b0, 3, 32'd5, 1'b1);

    // Timeout with TIMEOUT=8
    chData[63:32] = 32'hABCD;
    chSign        = 4'b0000;
    req = 4'b0010;
    tick;
    req = 4'b0000;
    tick;
    tick;
    checkOutput("toRunData", fltDatain, 32'hABCD);
    onCount = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (!fltEnable) break;
      onCount++;
    end
    checkOutput("toEnableCycles", 32'(onCount), 32'd8);
    checkOutput("toPulse", 32'(timeoutErr), 32'd1);
    checkOutput("toNoValid", 32'(resultValid), 32'd0);
    checkOutput("toResultKept", result, 32'd5);
    checkOutput("toBusy", 32'(busy), 32'd0);
    tick;
    checkOutput("toPulseEnd", 32'(timeoutErr), 32'd0);
    tick;
    checkOutput("toPendingCleared", 32'(busy), 32'd0);

    // Overrun flags on a waiting channel
    doReset;
    chData = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    chSign = 4'b0000;
    req = 4'b0101;
    tick;
    req = 4'b0000;
    tick;
    checkOutput("ovrNone", 32'(overrun), 32'd0);
    req = 4'b0100;
    tick;
    checkOutput("ovrRunData", fltDatain, 32'h1111);
    checkOutput("ovrSet", 32'(overrun), 32'h4);
    applyStimulus(4'b0000, 1'b0, 32'd0, 1'b1);
    tick;
    checkOutput("ovrClear", 32'(overrun), 32'h0);
    applyStimulus(4'b0100, 1'b0, 32'd0, 1'b1);
    tick;
    checkOutput("ovrSetWins", 32'(overrun), 32'h4);
    applyStimulus(4'b0001, 1'b1, 32'h77, 1'b0);
    tick;
    applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
    checkOutput("ovrDoneValid", 32'(resultValid), 32'd1);
    checkOutput("ovrDoneCh", 32'(resultCh), 32'd0);
    checkOutput("ovrSelfReq", 32'(overrun), 32'h4);
    serviceJob(2'd2, 32'h3333, 1'b0, 2, 32'h88, 1'b0);
    serviceJob(2'd0, 32'h1111, 1'b0, 2, 32'h99, 1'b0);

    // Reset in the middle of a job
    doReset;
    req = 4'b0011;
    tick;
    req = 4'b0000;
    tick;
    tick;
    checkOutput("midRunEnable", 32'(fltEnable), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstEnable", 32'(fltEnable), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checkOutput("postRstBusy", 32'(busy), 32'd0);
      checkOutput("postRstValid", 32'(resultValid), 32'd0);
    end
    checkOutput("postRstResult", result, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/filter_scheduler.md
FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 SHALL have parameter: NCH, 4, number of requesting channels (fixed at 4; 2-bit channel index).
REQ-002 SHALL have parameter: TIMEOUT, 1023, maximum RUN cycles allowed before a job is aborted (range 2..65535).
REQ-003 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: req  input  4  per-channel sample-ready strobe, sampled every cycle.
REQ-006 SHALL have port: ch_data  input  128  channel c magnitude on bits [32c+31:32c].
REQ-007 SHALL have port: ch_sign  input  4  per-channel sign bit (1 = negate result).
REQ-008 SHALL have port: clr_ovr  input  1  clears all sticky overrun flags.
REQ-009 SHALL have port: flt_enable  output  1  enable to the shared filter datapath.
REQ-010 SHALL have port: flt_datain  output  32  operand for the shared datapath.
REQ-011 SHALL have port: flt_sign  output  1  sign for the shared datapath.
REQ-012 SHALL have port: flt_over  input  1  datapath completion pulse.
REQ-013 SHALL have port: flt_result  input  32  datapath result, valid when flt_over=1.
REQ-014 SHALL have port: result  output  32  captured result of the last completed job.
REQ-015 SHALL have port: result_ch  output  2  channel index of result.
REQ-016 SHALL have port: result_valid  output  1  one-cycle pulse, new result.
REQ-017 SHALL have port: timeout_err  output  1  one-cycle pulse, job aborted.
REQ-018 SHALL have port: overrun  output  4  sticky per-channel overrun flags.
REQ-019 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL keep pending[3:0]: bit c set at the edge where req[c]=1, cleared when channel c's job completes or times out; set wins over clear in the same cycle.
REQ-021 SHALL set overrun[c] when req[c]=1 while pending[c]=1 and c is not the channel completing that cycle; clr_ovr clears all bits; a simultaneous set wins over clr_ovr.
REQ-022 SHALL implement FSM IDLE -> LOAD -> RUN -> IDLE; busy=1 in LOAD and RUN.
REQ-023 IDLE: if pending!=0, SHALL grant the first pending channel searching round-robin from last_grant+1 (mod 4), record grant and last_grant, go to LOAD; else stay.
REQ-024 LOAD: SHALL register flt_datain=ch_data[grant], flt_sign=ch_sign[grant]; flt_enable stays 0 (guaranteed low cycle so the datapath sees a rising edge); next state RUN.
REQ-025 RUN: SHALL hold flt_enable=1, flt_datain and flt_sign constant; cycle counter starts at 0 on entry and increments each RUN cycle.
REQ-026 RUN with flt_over=1: SHALL register result=flt_result, result_ch=grant, pulse result_valid for exactly one cycle, clear pending[grant], go IDLE.
REQ-027 RUN with counter=TIMEOUT-1 and flt_over=0: SHALL pulse timeout_err for one cycle, clear pending[grant], leave result unchanged, go IDLE.
REQ-028 flt_over and the timeout condition in the same cycle SHALL be treated as completion (REQ-026).
REQ-029 flt_over outside RUN SHALL be ignored.
REQ-030 Latency: req at edge k from idle -> flt_enable=1 after edge k+2; flt_over at edge m -> result_valid=1 and flt_enable=0 after edge m.
REQ-031 flt_enable SHALL be low for at least two cycles (IDLE, LOAD) between consecutive jobs.
REQ-032 ch_data and ch_sign SHALL be sampled only in LOAD; later changes do not affect the running job.

Reset
REQ-033 On rst_n=0, SHALL asynchronously force: state IDLE; pending, overrun 0; last_grant 3 (channel 0 has first priority); flt_enable, flt_sign, result_valid, timeout_err, busy 0; flt_datain, result 0; result_ch 0; counter 0.
REQ-034 Reset asserted mid-job SHALL drop flt_enable immediately, discard all pending requests and report nothing.

Verification
REQ-035 req=0001, ch_data[31:0]=50000, sign 0; flt_over with flt_result=5 three RUN cycles later -> flt_enable high 3 cycles, result=5, result_ch=0, result_valid for 1 cycle.
REQ-036 req=1111 in one cycle, datapath answers after 2 RUN cycles -> grants in order 0,1,2,3; four result_valid pulses; flt_enable low >=2 cycles between jobs.
REQ-037 TIMEOUT=8, flt_over never asserted -> flt_enable high exactly 8 cycles, timeout_err one pulse, result unchanged, pending[grant] cleared.
REQ-038 Channel 2 pending and waiting, req[2] pulsed again -> overrun=0100; clr_ovr -> 0000; req[2] and clr_ovr together -> 0100.
REQ-039 rst_n low during RUN -> flt_enable, busy 0 immediately; after release with req=0 the block stays IDLE and result_valid stays 0.
REQ-040 flt_over pulse in IDLE with no pending -> no result_valid, result unchanged.
